alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Registered EX-stage output buffer that sits directly downstream of the 16-bit saturating adder/subtractor. It captures the saturated sum and overflow bit, derives the Z/V/N condition flags, and maintains the architectural flag register. It hands results to the MEM stage over a valid/ready handshake. A two-entry skid buffer lets the stage hold full throughput while MEM stalls, and a flush input squashes in-flight results on a branch mispredict.

## Interface
- WIDTH, 16, datapath width; must match the adder width.
- TAGW, 4, width of the destination-register tag passed through with each result.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  adder result valid this cycle.
- in_ready  output  1  stage can accept a result; equals NOT skid_valid.
- in_result  input  WIDTH  saturated sum from the adder.
- in_ovf  input  1  adder overflow flag.
- in_fmode  input  2  flag update class: 00 none, 01 Z only, 10 Z/V/N, 11 reserved (treated as 00).
- in_tag  input  TAGW  destination-register tag.
- flush  input  1  squash all buffered results.
- out_valid  output  1  result available to MEM.
- out_ready  input  1  MEM accepts the result.
- out_result  output  WIDTH  buffered result.
- out_tag  output  TAGW  buffered tag.
- flags  output  3  architectural flags {Z,V,N}.

## Operation
- Accept: `acc = in_valid & in_ready & ~flush`.
- Flags from the accepted input:
  - Z = (in_result == 0)
  - V = in_ovf
  - N = in_result[WIDTH-1]
- Flag write on acc:
  - fmode 10 writes all three flags.
  - fmode 01 writes Z only; V and N hold.
  - fmode 00 and 11 write nothing.
- Flags update in acceptance order, not drain order. A later stall or flush never reverts them.
- Storage is a main entry (drives out_*) and a skid entry, each with its own valid bit.
- Next-state rules, with `drain = out_valid & out_ready`:
  - flush: main_valid and skid_valid clear. Data holds. flush overrides both acc and drain.
  - drain & skid_valid: skid moves to main; skid_valid clears. in_ready is 0, so acc cannot also occur.
  - drain & ~skid_valid: main loads the input if acc; otherwise main_valid clears.
  - ~drain & main_valid & acc: input loads into skid.
  - ~main_valid & acc: input loads into main.
- Ordering is strict FIFO; skid data never bypasses main.
- When out_valid is 1 and out_ready is 0, out_result and out_tag are held stable.

## Timing
- Reset values:
  - out_valid 0
  - in_ready 1
  - flags 3'b000
  - out_result 0
  - out_tag 0
  - internal valid bits 0
- Reset mid-transfer discards both entries.
- Latency: a result accepted at edge N appears on out_* after edge N and is consumed at edge N+1 if out_ready is high.
- Throughput is 1 result/cycle with out_ready held high.
- in_ready is registered (NOT skid_valid). No combinational path runs from out_ready to in_ready.
- in_ready drops the cycle after the skid entry fills. It rises the cycle after the skid entry drains.
- flags update on the same edge as acc.
- Flush takes effect at the edge where it is sampled. out_valid is 0 in the following cycle.

## Configuration
- FLAG_BYPASS_EN
  - Defined: `flags` is combinational. On an acc cycle it shows the value being written that cycle, so the branch unit sees the new flags with zero delay.
  - Undefined: `flags` is the register output only, and new values appear one cycle after acc.
  - Register contents and reset value are identical in both builds.

## Test plan
- Reset, then accept result 0x0000 with fmode 10, ovf 0, out_ready 1:
  - flags = {1,0,0} after the edge.
  - out_result = 0x0000, out_valid = 1 for 1 cycle.
- Accept 0x7FFF with ovf 1, fmode 10, then 0x8000 with ovf 0, fmode 01:
  - flags = {0,1,0}, then {0,1,0} (only Z is rewritten).
- Hold out_ready 0 and offer 3 back-to-back results with tags 1, 2, 3:
  - tags 1 and 2 are accepted; in_ready drops and tag 3 stalls.
  - Raising out_ready drains tags 1, 2, 3 in order with no loss or duplicate.
- Skid full, then assert flush together with in_valid:
  - out_valid = 0 next cycle, in_ready = 1, and flags are unchanged by the flushed input.
- Assert rst asynchronously mid-stall:
  - out_valid and flags clear immediately, without waiting for a clock edge.
- With FLAG_BYPASS_EN: flags equal the new value in the acc cycle. Without it: the new value appears one cycle later.

Source files
------------

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - EX-stage result buffer with two-entry skid, flush and Z/V/N flag register.
// Optional FLAG_BYPASS_EN: drive flags combinationally with the value written on an accept cycle.
module alu_result_stage #(
   parameter int WIDTH = 16,
   parameter int TAGW  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_ovf,
   input  logic [1:0]       in_fmode,
   input  logic [TAGW-1:0]  in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [TAGW-1:0]  out_tag,
   output logic [2:0]       flags
);

   logic             main_valid;
   logic             skid_valid;
   logic [WIDTH-1:0] main_result;
   logic [WIDTH-1:0] skid_result;
   logic [TAGW-1:0]  main_tag;
   logic [TAGW-1:0]  skid_tag;
   logic [2:0]       flag_reg;
   logic [2:0]       flag_next;
   logic             acc;
   logic             drain;
   logic             zero;

   // in_ready comes straight from a flop, so out_ready never reaches it combinationally
   assign in_ready   = ~skid_valid;
   assign out_valid  = main_valid;
   assign out_result = main_result;
   assign out_tag    = main_tag;

   assign acc   = in_valid & in_ready & ~flush;
   assign drain = main_valid & out_ready;
   assign zero  = (in_result == '0);

   always_comb begin
      flag_next = flag_reg;
      case (in_fmode)
         2'b10:   flag_next = {zero, in_ovf, in_result[WIDTH-1]};
         2'b01:   flag_next[2] = zero;
         default: flag_next = flag_reg;
      endcase
   end

`ifdef FLAG_BYPASS_EN
   assign flags = acc ? flag_next : flag_reg;
`else
   assign flags = flag_reg;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_reg <= 3'b000;
      end else if (acc) begin
         flag_reg <= flag_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid  <= 1'b0;
         skid_valid  <= 1'b0;
         main_result <= '0;
         skid_result <= '0;
         main_tag    <= '0;
         skid_tag    <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (drain && skid_valid) begin
         main_result <= skid_result;
         main_tag    <= skid_tag;
         skid_valid  <= 1'b0;
      end else if (drain) begin
         main_valid <= acc;
         if (acc) begin
            main_result <= in_result;
            main_tag    <= in_tag;
         end
      end else if (acc && main_valid) begin
         skid_valid  <= 1'b1;
         skid_result <= in_result;
         skid_tag    <= in_tag;
      end else if (acc) begin
         main_valid  <= 1'b1;
         main_result <= in_result;
         main_tag    <= in_tag;
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage against a queue-based model.
module tb_alu_result_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic        in_ovf;
   logic [1:0]  in_fmode;
   logic [3:0]  in_tag;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [3:0]  out_tag;
   logic [2:0]  flags;

   int checks = 0;
   int failures = 0;

   logic [19:0] q[$];
   logic [2:0]  mflags;

   alu_result_stage #(.WIDTH(16), .TAGW(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_ovf(in_ovf), .in_fmode(in_fmode), .in_tag(in_tag),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag),
      .flags(flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] fnew(input logic [15:0] r, input logic o,
                                       input logic [1:0] m, input logic [2:0] old);
      case (m)
         2'b10:   return {r == 16'h0, o, r[15]};
         2'b01:   return {r == 16'h0, old[1:0]};
         default: return old;
      endcase
   endfunction

   // reference: up to two results in order, flags follow acceptance order
   always @(negedge clk) begin
      logic       acc;
      logic [2:0] fexp;
      if (rst) begin
         q.delete();
         mflags = 3'b000;
      end else begin
         acc = in_valid && (q.size() < 2) && !flush;
         chk("m_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
         chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
         if (q.size() > 0) begin
            chk("m_out_result", {16'd0, out_result}, {16'd0, q[0][19:4]});
            chk("m_out_tag", {28'd0, out_tag}, {28'd0, q[0][3:0]});
         end
`ifdef FLAG_BYPASS_EN
         fexp = acc ? fnew(in_result, in_ovf, in_fmode, mflags) : mflags;
`else
         fexp = mflags;
`endif
         chk("m_flags", {29'd0, flags}, {29'd0, fexp});
         if (flush) begin
            q.delete();
         end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back({in_result, in_tag});
         end
         if (acc) mflags = fnew(in_result, in_ovf, in_fmode, mflags);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [15:0] r, input logic o, input logic [1:0] m, input logic [3:0] t);
      in_valid = 1'b1; in_result = r; in_ovf = o; in_fmode = m; in_tag = t;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] got[$];
      logic       took;
      rst = 1'b1; in_valid = 0; in_result = 0; in_ovf = 0; in_fmode = 0; in_tag = 0;
      flush = 0; out_ready = 1;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      cyc();
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 1);
      chk("rst_flags", {29'd0, flags}, 0);
      chk("rst_out_result", {16'd0, out_result}, 0);
      chk("rst_out_tag", {28'd0, out_tag}, 0);

      offer(16'h0000, 1'b0, 2'b10, 4'h5);
      cyc();
      in_valid = 0;
      #1;
      chk("zero_flags", {29'd0, flags}, 3'b100);
      chk("zero_out_valid", {31'd0, out_valid}, 1);
      chk("zero_out_result", {16'd0, out_result}, 0);
      cyc();
      chk("zero_one_cycle", {31'd0, out_valid}, 0);

      offer(16'h7FFF, 1'b1, 2'b10, 4'h1);
      cyc();
      in_valid = 0; #1;
      chk("ovf_flags", {29'd0, flags}, 3'b010);
      offer(16'h8000, 1'b0, 2'b01, 4'h2);
      cyc();
      in_valid = 0; #1;
      chk("zonly_flags", {29'd0, flags}, 3'b010);

      offer(16'h0000, 1'b0, 2'b01, 4'h3);
      #1;
`ifdef FLAG_BYPASS_EN
      chk("bypass_acc_cycle", {29'd0, flags}, 3'b110);
`else
      chk("nobypass_acc_cycle", {29'd0, flags}, 3'b010);
`endif
      cyc();
      in_valid = 0; #1;
      chk("after_acc_flags", {29'd0, flags}, 3'b110);
      repeat (2) cyc();

      out_ready = 0;
      offer(16'h0011, 1'b0, 2'b00, 4'd1); cyc();
      offer(16'h0022, 1'b0, 2'b00, 4'd2); cyc();
      offer(16'h0033, 1'b0, 2'b00, 4'd3); cyc();
      chk("stall_in_ready", {31'd0, in_ready}, 0);
      chk("stall_head_tag", {28'd0, out_tag}, 1);
      cyc();
      chk("stall_hold_tag", {28'd0, out_tag}, 1);
      chk("stall_hold_result", {16'd0, out_result}, 16'h0011);
      out_ready = 1;
      took = 0;
      for (int i = 0; i < 10 && got.size() < 3; i++) begin
         if (took) in_valid = 0;
         #1;
         if (out_valid) got.push_back(out_tag);
         if (in_valid && in_ready) took = 1;
         cyc();
      end
      in_valid = 0;
      chk("drain_count", got.size(), 3);
      for (int i = 0; i < 3; i++)
         chk("drain_order", (i < got.size()) ? {28'd0, got[i]} : 32'hDEAD, i + 1);
      repeat (2) cyc();

      out_ready = 0;
      offer(16'h0044, 1'b0, 2'b00, 4'd4); cyc();
      offer(16'h0055, 1'b0, 2'b00, 4'd5); cyc();
      chk("full_in_ready", {31'd0, in_ready}, 0);
      offer(16'h0000, 1'b1, 2'b10, 4'd9);
      flush = 1;
      cyc();
      flush = 0; in_valid = 0; #1;
      chk("flush_out_valid", {31'd0, out_valid}, 0);
      chk("flush_in_ready", {31'd0, in_ready}, 1);
      chk("flush_flags", {29'd0, flags}, {29'd0, mflags});
      chk("flush_flags_lit", {29'd0, flags}, 3'b110);

      offer(16'hFFFF, 1'b1, 2'b10, 4'd6); cyc();
      offer(16'h1234, 1'b1, 2'b10, 4'd7); cyc();
      in_valid = 0; #1;
      chk("prerst_flags", {29'd0, flags}, 3'b010);
      chk("prerst_out_valid", {31'd0, out_valid}, 1);
      rst = 1'b1;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 0);
      chk("arst_flags", {29'd0, flags}, 0);
      chk("arst_in_ready", {31'd0, in_ready}, 1);
      @(negedge clk);
      #1 rst = 1'b0;
      out_ready = 1;
      cyc();

      for (int i = 0; i < 1500; i++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 20) == 0;
         case ($urandom % 5)
            0: in_result = 16'h0000;
            1: in_result = 16'h8000;
            2: in_result = 16'h7FFF;
            default: in_result = 16'($urandom);
         endcase
         in_ovf   = 1'($urandom);
         in_fmode = 2'($urandom);
         in_tag   = 4'($urandom);
         cyc();
      end
      in_valid = 0; flush = 0; out_ready = 1;
      repeat (4) cyc();
      chk("end_empty", {31'd0, out_valid}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
